data_memory_io: RTL and testbench
=================================

Name: data_memory_io

Overview:
- Load/store responder on the far side of the CPU datapath's memory interface.
- Decodes an 8-bit data address into 240 bytes of data RAM plus 16 memory-mapped I/O ports.
- I/O ports cover the pixel screen, character display, number display, RNG and controller.
- Returns load data on load_bus. Drives double-buffered display state toward the output/display logic.

Parameters:
- RAM_DEPTH, 240, bytes of general RAM at addresses 0..RAM_DEPTH-1.
- CHAR_SLOTS, 10, character display width in characters.
- LFSR_SEED, 8'h01, RNG value after reset; must be nonzero.

Ports:
- clk  input  1  system clock, rising edge.
- sync_rst  input  1  synchronous active-high reset.
- mem_addr_bus  input  8  byte address from datapath.
- store_bus  input  8  store data from datapath.
- mem_we  input  1  store strobe, one cycle per store.
- mem_re  input  1  load strobe, one cycle per load.
- load_bus  output  8  registered load data to datapath.
- ctrl_in  input  8  controller buttons, asynchronous to program flow.
- screen_out  output  1024  front framebuffer; bit index y*32+x.
- chars_out  output  5*CHAR_SLOTS  front char buffer; slot 0 in bits [4:0].
- number_out  output  8  displayed number.
- number_valid  output  1  number display enabled.
- number_signed  output  1  1 = display number_out as two's complement.

Behaviour:
- All state updates on the rising edge of clk. sync_rst has priority over mem_we and mem_re.
- Reset values:
  - load_bus=0
  - both framebuffers=0
  - both char buffers=0 and char pointer=0
  - pixel_x=pixel_y=0
  - number_out=0, number_valid=0, number_signed=0
  - LFSR=LFSR_SEED
  - ctrl sync stage=0
  - RAM contents not reset (undefined until written).
- Load:
  - On the edge where mem_re=1, load_bus <= data(mem_addr_bus). Data is valid the cycle after the strobe.
  - load_bus holds its value until the next mem_re.
- Simultaneous mem_re and mem_we to the same address: the load returns the pre-store value (read-before-write).
- RAM (addr < RAM_DEPTH): store writes the byte; load returns the byte.
- I/O map (store effect / load result; unlisted load result = 0):
  - 240 pixel_x <= store_bus[4:0]
  - 241 pixel_y <= store_bus[4:0]
  - 242 store: set back-buffer pixel (pixel_x, pixel_y)
  - 243 store: clear back-buffer pixel
  - 244 load: {7'b0, back-buffer pixel}
  - 245 store: front framebuffer <= back framebuffer
  - 246 store: back framebuffer <= 0
  - 247 store: back char[ptr] <= store_bus[4:0]; ptr <= (ptr==CHAR_SLOTS-1) ? 0 : ptr+1
  - 248 store: front chars <= back chars
  - 249 store: back chars <= 0, ptr <= 0
  - 250 store: number_out <= store_bus, number_valid <= 1
  - 251 store: number_valid <= 0 (number_out held)
  - 252 store: number_signed <= 1
  - 253 store: number_signed <= 0
  - 254 load: current LFSR value
  - 255 load: ctrl_sync
- Stored data is ignored for ports 242, 243, 245, 246 and 248, 249, 251..253.
- Pixel ops use the pixel_x/pixel_y values registered before the current edge.
- Write to a read-only port (244, 254, 255) is a no-op.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1, shifts right every cycle regardless of access. Never reaches 0.
- ctrl_in passes through one sync flop per cycle into ctrl_sync. A load of 255 returns ctrl_sync as it stood before the edge.

Decomposition:
- Package bat_io_pkg holds:
  - I/O address localparams (IO_PIXEL_X=240 .. IO_CONTROLLER=255)
  - SCREEN_W=32, CHAR_BITS=5
  - LFSR tap mask.
- Sub-module rng_lfsr (clk, sync_rst, seed param, 8-bit out).
- RAM and I/O decode stay in data_memory_io.

Test Plan:
- Write 0xA5 to addr 7, then a later mem_re on addr 7 -> load_bus=0xA5 the cycle after the strobe; unchanged until the next mem_re.
- Same cycle: mem_we 0x11 and mem_re on addr 3, which previously held 0x22 -> load_bus=0x22; next load of addr 3 returns 0x11.
- Pixel sequence:
  - x=5, y=2, store 242 -> load 244 returns 1; screen_out bit 69 still 0.
  - Store 245 -> screen_out bit 69=1.
  - Store 246 then load 244 -> 0; screen_out unchanged.
- Char pointer wrap: store 11 chars 1..11 to 247, then store 248 -> chars_out slot0=11, slots1..9=2..10.
- Number display:
  - Store 0xFE to 250, then store 252 -> number_out=0xFE, valid=1, signed=1.
  - Store 251 -> valid=0, number_out=0xFE.
- RNG/controller:
  - Load 254 on the first cycle after reset release -> returns 0x01, and later loads differ and never return 0.
  - Set ctrl_in=0x3C, wait 2 cycles, load 255 -> returns 0x3C.
  - Assert sync_rst mid-sequence -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/bat_io_pkg.sv
// Shared constants for the data memory / memory-mapped I/O block:
// I/O port addresses, display geometry and the RNG step function.
package bat_io_pkg;

  localparam logic [7:0] IO_PIXEL_X      = 8'd240;
  localparam logic [7:0] IO_PIXEL_Y      = 8'd241;
  localparam logic [7:0] IO_PIXEL_SET    = 8'd242;
  localparam logic [7:0] IO_PIXEL_CLR    = 8'd243;
  localparam logic [7:0] IO_PIXEL_READ   = 8'd244;
  localparam logic [7:0] IO_SCREEN_SWAP  = 8'd245;
  localparam logic [7:0] IO_SCREEN_CLR   = 8'd246;
  localparam logic [7:0] IO_CHAR_PUSH    = 8'd247;
  localparam logic [7:0] IO_CHAR_SWAP    = 8'd248;
  localparam logic [7:0] IO_CHAR_CLR     = 8'd249;
  localparam logic [7:0] IO_NUM_SET      = 8'd250;
  localparam logic [7:0] IO_NUM_OFF      = 8'd251;
  localparam logic [7:0] IO_NUM_SIGNED   = 8'd252;
  localparam logic [7:0] IO_NUM_UNSIGNED = 8'd253;
  localparam logic [7:0] IO_RNG          = 8'd254;
  localparam logic [7:0] IO_CONTROLLER   = 8'd255;

  localparam int SCREEN_W  = 32;
  localparam int CHAR_BITS = 5;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef logic [7:0] byte_t;

  function automatic byte_t lfsr_step(input byte_t v);
    return (v >> 3'd1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/data_memory_io_if.sv
// Load/store bus between the CPU datapath (master) and the data memory (slave).
interface data_memory_io_if;
  logic [7:0] mem_addr_bus;
  logic [7:0] store_bus;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] load_bus;

  modport master (output mem_addr_bus, output store_bus, output mem_we,
                  output mem_re, input load_bus);
  modport slave  (input mem_addr_bus, input store_bus, input mem_we,
                  input mem_re, output load_bus);
endinterface

// File: rtl/data_memory_io_rng_lfsr.sv
// Free-running 8-bit Galois LFSR; advances on every clock edge once out of reset.
module rng_lfsr
  import bat_io_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       sync_rst,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/data_memory_io.sv
// Data RAM plus memory-mapped display, RNG and controller ports behind one
// 8-bit load/store bus. Display state is double buffered (back written, front shown).
module data_memory_io
  import bat_io_pkg::*;
#(
  parameter int         RAM_DEPTH  = 240,
  parameter int         CHAR_SLOTS = 10,
  parameter logic [7:0] LFSR_SEED  = 8'h01
) (
  input  logic                            clk,
  input  logic                            sync_rst,
  data_memory_io_if.slave                 mem,
  input  logic [7:0]                      ctrl_in,
  output logic [SCREEN_W*SCREEN_W-1:0]    screen_out,
  output logic [CHAR_BITS*CHAR_SLOTS-1:0] chars_out,
  output logic [7:0]                      number_out,
  output logic                            number_valid,
  output logic                            number_signed
);

  localparam int         PTR_W     = $clog2(CHAR_SLOTS);
  localparam int         PIX_W     = $clog2(SCREEN_W);
  localparam int         FB_BITS   = SCREEN_W * SCREEN_W;
  localparam logic [8:0] RAM_LIMIT = 9'(RAM_DEPTH);

  typedef logic [CHAR_SLOTS-1:0][CHAR_BITS-1:0] chars_t;

  logic [7:0]         ram_q [RAM_DEPTH];
  logic [7:0]         load_q, load_d;
  logic [PIX_W-1:0]   px_q, px_d, py_q, py_d;
  logic [FB_BITS-1:0] back_fb_q, back_fb_d, front_fb_q, front_fb_d;
  chars_t             back_ch_q, back_ch_d, front_ch_q, front_ch_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         num_q, num_d;
  logic               nvalid_q, nvalid_d, nsigned_q, nsigned_d;
  logic [7:0]         ctrl_q;
  logic [7:0]         lfsr_s, rd_data_s, io_sel_s;
  logic               is_ram_s;
  logic [2*PIX_W-1:0] pix_idx_s;

  rng_lfsr #(.SEED(LFSR_SEED)) u_rng (
    .clk      (clk),
    .sync_rst (sync_rst),
    .lfsr_o   (lfsr_s)
  );

  assign is_ram_s  = ({1'b0, mem.mem_addr_bus} < RAM_LIMIT);
  assign pix_idx_s = {py_q, px_q};
  // Address 0 is RAM and never matches an I/O port, so it doubles as "no I/O store".
  assign io_sel_s  = (mem.mem_we && !is_ram_s) ? mem.mem_addr_bus : 8'h00;

  always_comb begin
    rd_data_s = 8'h00;
    if (is_ram_s) begin
      rd_data_s = ram_q[mem.mem_addr_bus];
    end else begin
      case (mem.mem_addr_bus)
        IO_PIXEL_READ: rd_data_s = {7'b0000000, back_fb_q[pix_idx_s]};
        IO_RNG:        rd_data_s = lfsr_s;
        IO_CONTROLLER: rd_data_s = ctrl_q;
        default:       rd_data_s = 8'h00;
      endcase
    end
  end

  always_comb begin
    load_d     = mem.mem_re ? rd_data_s : load_q;
    px_d       = px_q;
    py_d       = py_q;
    back_fb_d  = back_fb_q;
    front_fb_d = front_fb_q;
    back_ch_d  = back_ch_q;
    front_ch_d = front_ch_q;
    ptr_d      = ptr_q;
    num_d      = num_q;
    nvalid_d   = nvalid_q;
    nsigned_d  = nsigned_q;
    case (io_sel_s)
      IO_PIXEL_X:      px_d = mem.store_bus[PIX_W-1:0];
      IO_PIXEL_Y:      py_d = mem.store_bus[PIX_W-1:0];
      IO_PIXEL_SET:    back_fb_d[pix_idx_s] = 1'b1;
      IO_PIXEL_CLR:    back_fb_d[pix_idx_s] = 1'b0;
      IO_SCREEN_SWAP:  front_fb_d = back_fb_q;
      IO_SCREEN_CLR:   back_fb_d = {FB_BITS{1'b0}};
      IO_CHAR_PUSH: begin
        back_ch_d[ptr_q] = mem.store_bus[CHAR_BITS-1:0];
        ptr_d = (ptr_q == PTR_W'(CHAR_SLOTS - 1)) ? {PTR_W{1'b0}} : ptr_q + PTR_W'(1);
      end
      IO_CHAR_SWAP:    front_ch_d = back_ch_q;
      IO_CHAR_CLR: begin
        back_ch_d = {(CHAR_SLOTS*CHAR_BITS){1'b0}};
        ptr_d     = {PTR_W{1'b0}};
      end
      IO_NUM_SET: begin
        num_d    = mem.store_bus;
        nvalid_d = 1'b1;
      end
      IO_NUM_OFF:      nvalid_d = 1'b0;
      IO_NUM_SIGNED:   nsigned_d = 1'b1;
      IO_NUM_UNSIGNED: nsigned_d = 1'b0;
      default:         num_d = num_q;
    endcase
  end

  // RAM is intentionally not reset; stores are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (mem.mem_we && is_ram_s && !sync_rst) begin
      ram_q[mem.mem_addr_bus] <= mem.store_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      load_q     <= 8'h00;
      px_q       <= {PIX_W{1'b0}};
      py_q       <= {PIX_W{1'b0}};
      back_fb_q  <= {FB_BITS{1'b0}};
      front_fb_q <= {FB_BITS{1'b0}};
      back_ch_q  <= {(CHAR_SLOTS*CHAR_BITS){1'b0}};
      front_ch_q <= {(CHAR_SLOTS*CHAR_BITS){1'b0}};
      ptr_q      <= {PTR_W{1'b0}};
      num_q      <= 8'h00;
      nvalid_q   <= 1'b0;
      nsigned_q  <= 1'b0;
      ctrl_q     <= 8'h00;
    end else begin
      load_q     <= load_d;
      px_q       <= px_d;
      py_q       <= py_d;
      back_fb_q  <= back_fb_d;
      front_fb_q <= front_fb_d;
      back_ch_q  <= back_ch_d;
      front_ch_q <= front_ch_d;
      ptr_q      <= ptr_d;
      num_q      <= num_d;
      nvalid_q   <= nvalid_d;
      nsigned_q  <= nsigned_d;
      ctrl_q     <= ctrl_in;
    end
  end

  assign mem.load_bus  = load_q;
  assign screen_out    = front_fb_q;
  assign chars_out     = front_ch_q;
  assign number_out    = num_q;
  assign number_valid  = nvalid_q;
  assign number_signed = nsigned_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Randomized bench for data_memory_io: a behavioural memory/display model queues
// expected load data; a monitor on the falling edge compares every output.
module tb_data_memory_io;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic [7:0]    ctrl_in;
  logic [1023:0] screen_out;
  logic [49:0]   chars_out;
  logic [7:0]    number_out;
  logic          number_valid;
  logic          number_signed;

  always #5 clk = ~clk;

  data_memory_io_if bus ();

  data_memory_io dut (
    .clk           (clk),
    .sync_rst      (sync_rst),
    .mem           (bus),
    .ctrl_in       (ctrl_in),
    .screen_out    (screen_out),
    .chars_out     (chars_out),
    .number_out    (number_out),
    .number_valid  (number_valid),
    .number_signed (number_signed)
  );

  // Reference model state
  bit [7:0] ram_m [240];
  int       px, py, ptr;
  bit       back_fb [32][32];
  bit       front_fb [32][32];
  int       back_ch [10];
  int       front_ch [10];
  bit [7:0] num_m;
  bit       nval_m, nsgn_m;
  bit [7:0] lfsr_m, ctrl_m;
  bit [7:0] exp_q [$];

  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [7:0] hold_exp;

  task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic bit [7:0] model_read(input bit [7:0] a);
    if (a < 8'd240) return ram_m[a];
    case (a)
      8'd244:  return {7'd0, back_fb[py][px]};
      8'd254:  return lfsr_m;
      8'd255:  return ctrl_m;
      default: return 8'd0;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit we, input bit re,
                            input bit [7:0] a, input bit [7:0] d, input bit [7:0] c);
    if (rst) begin
      exp_q.push_back(8'h00);
      px = 0; py = 0; ptr = 0;
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) begin
          back_fb[y][x] = 1'b0;
          front_fb[y][x] = 1'b0;
        end
      for (int i = 0; i < 10; i++) begin
        back_ch[i] = 0;
        front_ch[i] = 0;
      end
      num_m = 8'h00; nval_m = 1'b0; nsgn_m = 1'b0;
      lfsr_m = 8'h01; ctrl_m = 8'h00;
      return;
    end
    if (re) exp_q.push_back(model_read(a));
    if (we) begin
      if (a < 8'd240) ram_m[a] = d;
      else case (a)
        8'd240: px = int'(d) % 32;
        8'd241: py = int'(d) % 32;
        8'd242: back_fb[py][px] = 1'b1;
        8'd243: back_fb[py][px] = 1'b0;
        8'd245: front_fb = back_fb;
        8'd246: for (int y = 0; y < 32; y++)
                  for (int x = 0; x < 32; x++) back_fb[y][x] = 1'b0;
        8'd247: begin
          back_ch[ptr] = int'(d) % 32;
          ptr = (ptr + 1) % 10;
        end
        8'd248: front_ch = back_ch;
        8'd249: begin
          for (int i = 0; i < 10; i++) back_ch[i] = 0;
          ptr = 0;
        end
        8'd250: begin num_m = d; nval_m = 1'b1; end
        8'd251: nval_m = 1'b0;
        8'd252: nsgn_m = 1'b1;
        8'd253: nsgn_m = 1'b0;
        default: ;
      endcase
    end
    lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
    ctrl_m = c;
  endtask

  task automatic cyc(input bit rst, input bit we, input bit re,
                     input bit [7:0] a, input bit [7:0] d);
    sync_rst         = rst;
    bus.mem_we       = we;
    bus.mem_re       = re;
    bus.mem_addr_bus = a;
    bus.store_bus    = d;
    @(posedge clk);
    #1;
    model_edge(rst, we, re, a, d, ctrl_in);
  endtask

  task automatic st(input bit [7:0] a, input bit [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic ld(input bit [7:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Monitor: consume queued load results and compare every output each cycle
  initial begin
    logic [1023:0] exp_scr;
    logic [49:0]   exp_ch;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) hold_exp = exp_q.pop_front();
        for (int y = 0; y < 32; y++)
          for (int x = 0; x < 32; x++) exp_scr[y*32+x] = front_fb[y][x];
        for (int i = 0; i < 10; i++) exp_ch[i*5 +: 5] = 5'(front_ch[i]);
        chk("load_bus", 1024'(bus.load_bus), 1024'(hold_exp));
        chk("screen_out", screen_out, exp_scr);
        chk("chars_out", 1024'(chars_out), 1024'(exp_ch));
        chk("number_out", 1024'(number_out), 1024'(num_m));
        chk("number_valid", 1024'(number_valid), 1024'(nval_m));
        chk("number_signed", 1024'(number_signed), 1024'(nsgn_m));
      end
    end
  end

  initial begin
    ctrl_in = 8'h00;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    mon_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 8'd250, 8'h55);
    ld(8'd254);
    ld(8'd254);
    ld(8'd254);

    for (int a = 0; a < 240; a++) st(8'(a), 8'($urandom));
    st(8'd7, 8'hA5);
    st(8'd3, 8'h22);
    idle();
    ld(8'd7);
    idle(); idle();
    cyc(1'b0, 1'b1, 1'b1, 8'd3, 8'h11);
    ld(8'd3);

    st(8'd240, 8'd5);
    st(8'd241, 8'd2);
    st(8'd242, 8'hFF);
    ld(8'd244);
    st(8'd245, 8'h00);
    st(8'd246, 8'h00);
    ld(8'd244);
    st(8'd244, 8'hFF);
    st(8'd254, 8'h00);

    st(8'd249, 8'h00);
    for (int i = 1; i <= 11; i++) st(8'd247, 8'(i));
    st(8'd248, 8'h00);

    st(8'd250, 8'hFE);
    st(8'd252, 8'h00);
    st(8'd251, 8'h00);
    idle();

    ctrl_in = 8'h3C;
    idle(); idle();
    ld(8'd255);

    for (int n = 0; n < 1500; n++) begin
      bit [7:0] a;
      ctrl_in = 8'($urandom);
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    cyc(1'b1, 1'b1, 1'b1, 8'd250, 8'h77);
    ld(8'd254);
    ld(8'd7);

    for (int n = 0; n < 1500; n++) begin
      bit [7:0] a;
      ctrl_in = 8'($urandom);
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
